// File: rtl/gmii_rx_pkg.sv
// Shared types and constants for the GMII receive framing path.
package gmii_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_DROP     = 2'd3
    } rx_state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;
    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [10:0] LEN_SAT       = 11'h7FF;

endpackage

// File: rtl/crc32_d8.sv
// One-byte step of the reflected (LSB-first) Ethernet CRC-32, purely combinational.
module crc32_d8
    import gmii_rx_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    always_comb begin
        crc_out = crc_in ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            crc_out = crc_out[0] ? ((crc_out >> 1) ^ CRC_POLY) : (crc_out >> 1);
        end
    end

endmodule

// File: rtl/gmii_rx_frame_parser.sv
// GMII receive framer: strips preamble/SFD/FCS, checks length, error and (with
// GMII_RX_FCS_CHECK_EN defined) the CRC-32, and keeps good/bad frame counters.
//
// state       | meaning
// ST_IDLE     | waiting for a dv rising edge
// ST_PREAMBLE | consuming 0x55 bytes until the SFD
// ST_DATA     | frame body through a 5-byte delay line (hides the FCS)
// ST_DROP     | malformed preamble, discard until dv falls
module gmii_rx_frame_parser
    import gmii_rx_pkg::*;
#(
    parameter int MIN_FRAME_LEN = 64,
    parameter int MAX_FRAME_LEN = 1518
) (
    input  logic        gmii_rx_clk,
    input  logic        reset,
    input  logic [7:0]  gmii_rxd,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_sof,
    output logic        rx_eof,
    output logic        rx_stat_valid,
    output logic        rx_good,
    output logic [10:0] rx_frame_len,
    output logic [15:0] good_cnt,
    output logic [15:0] bad_cnt
);

    localparam logic [10:0] MIN_LEN = 11'(MIN_FRAME_LEN);
    localparam logic [10:0] MAX_LEN = 11'(MAX_FRAME_LEN);

    rx_state_t   state_q, state_next;
    logic        dv_d;
    logic [7:0]  dly_q [5];
    logic [2:0]  fill_q;
    logic [10:0] len_q;
    logic        err_q, sof_pend_q;
    logic        start_frame, push, emit, end_frame;
    logic        line_full, oversize, len_ok, fcs_ok, frame_good;

    assign line_full  = (fill_q == 3'd5);
    assign oversize   = (len_q > MAX_LEN);
    assign len_ok     = (len_q >= MIN_LEN) && !oversize;
    assign frame_good = !err_q && len_ok && fcs_ok;

    always_comb begin
        state_next  = state_q;
        start_frame = 1'b0;
        push        = 1'b0;
        emit        = 1'b0;
        end_frame   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gmii_rx_dv && !dv_d)
                    state_next = (gmii_rxd == PREAMBLE_BYTE) ? ST_PREAMBLE : ST_DROP;
            end
            ST_PREAMBLE: begin
                if (!gmii_rx_dv) begin
                    state_next = ST_IDLE;
                end else if (gmii_rxd == SFD_BYTE) begin
                    state_next  = ST_DATA;
                    start_frame = 1'b1;
                end else if (gmii_rxd != PREAMBLE_BYTE) begin
                    state_next = ST_DROP;
                end
            end
            ST_DATA: begin
                // The oldest byte leaves the line on every push, or once more at end of frame
                emit = line_full && !oversize;
                if (gmii_rx_dv) begin
                    push = 1'b1;
                end else begin
                    end_frame  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (!gmii_rx_dv)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge gmii_rx_clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            dv_d    <= 1'b1;
        end else begin
            state_q <= state_next;
            dv_d    <= gmii_rx_dv;
        end
    end

    always_ff @(posedge gmii_rx_clk or posedge reset) begin
        if (reset) begin
            fill_q     <= 3'd0;
            len_q      <= 11'd0;
            err_q      <= 1'b0;
            sof_pend_q <= 1'b0;
            for (int i = 0; i < 5; i++) dly_q[i] <= 8'd0;
        end else if (start_frame) begin
            fill_q     <= 3'd0;
            len_q      <= 11'd0;
            err_q      <= 1'b0;
            sof_pend_q <= 1'b1;
        end else begin
            if (emit) sof_pend_q <= 1'b0;
            if (push) begin
                dly_q[0] <= gmii_rxd;
                for (int i = 1; i < 5; i++) dly_q[i] <= dly_q[i-1];
                if (!line_full) fill_q <= fill_q + 3'd1;
                if (len_q != LEN_SAT) len_q <= len_q + 11'd1;
                if (gmii_rx_er) err_q <= 1'b1;
            end
        end
    end

`ifdef GMII_RX_FCS_CHECK_EN
    logic [31:0] crc_q, crc_next;

    crc32_d8 u_crc32_d8 (
        .crc_in  (crc_q),
        .data    (gmii_rxd),
        .crc_out (crc_next)
    );

    always_ff @(posedge gmii_rx_clk or posedge reset) begin
        if (reset)            crc_q <= CRC_INIT;
        else if (start_frame) crc_q <= CRC_INIT;
        else if (push)        crc_q <= crc_next;
    end

    assign fcs_ok = (crc_q == CRC_RESIDUE);
`else
    assign fcs_ok = 1'b1;
`endif

    always_ff @(posedge gmii_rx_clk or posedge reset) begin
        if (reset) begin
            rx_data       <= 8'd0;
            rx_valid      <= 1'b0;
            rx_sof        <= 1'b0;
            rx_eof        <= 1'b0;
            rx_stat_valid <= 1'b0;
            rx_good       <= 1'b0;
            rx_frame_len  <= 11'd0;
            good_cnt      <= 16'd0;
            bad_cnt       <= 16'd0;
        end else begin
            rx_valid      <= emit;
            rx_sof        <= emit && sof_pend_q;
            rx_eof        <= emit && end_frame;
            rx_stat_valid <= end_frame;
            if (emit) rx_data <= dly_q[4];
            if (end_frame) begin
                rx_good      <= frame_good;
                rx_frame_len <= (len_q >= 11'd4) ? (len_q - 11'd4) : 11'd0;
                if (frame_good) good_cnt <= good_cnt + 16'd1;
                else            bad_cnt  <= bad_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_gmii_rx_frame_parser.sv
// Directed scoreboard bench for gmii_rx_frame_parser; expectations follow GMII_RX_FCS_CHECK_EN.
`timescale 1ns/1ps
module tb_gmii_rx_frame_parser;

    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1518;
`ifdef GMII_RX_FCS_CHECK_EN
    localparam bit FCS_CHECKED = 1'b1;
`else
    localparam bit FCS_CHECKED = 1'b0;
`endif

    logic        gmii_rx_clk = 1'b0;
    logic        reset;
    logic [7:0]  gmii_rxd;
    logic        gmii_rx_dv;
    logic        gmii_rx_er;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_sof, rx_eof, rx_stat_valid, rx_good;
    logic [10:0] rx_frame_len;
    logic [15:0] good_cnt, bad_cnt;

    always #4 gmii_rx_clk = ~gmii_rx_clk;

    gmii_rx_frame_parser #(
        .MIN_FRAME_LEN (MIN_LEN),
        .MAX_FRAME_LEN (MAX_LEN)
    ) dut (
        .gmii_rx_clk   (gmii_rx_clk),
        .reset         (reset),
        .gmii_rxd      (gmii_rxd),
        .gmii_rx_dv    (gmii_rx_dv),
        .gmii_rx_er    (gmii_rx_er),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_sof        (rx_sof),
        .rx_eof        (rx_eof),
        .rx_stat_valid (rx_stat_valid),
        .rx_good       (rx_good),
        .rx_frame_len  (rx_frame_len),
        .good_cnt      (good_cnt),
        .bad_cnt       (bad_cnt)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       sof;
        logic       eof;
    } exp_byte_t;

    typedef struct packed {
        logic        good;
        logic [10:0] len;
        logic [15:0] gcnt;
        logic [15:0] bcnt;
    } exp_stat_t;

    exp_byte_t  exp_data_q[$];
    exp_stat_t  exp_stat_q[$];
    logic [7:0] frm[$];
    int checks = 0;
    int errors = 0;
    int exp_good = 0;
    int exp_bad = 0;

    function automatic logic [31:0] crc_update(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int b = 0; b < 8; b++) begin
            fb = r[0] ^ d[b];
            r  = {1'b0, r[31:1]} ^ (fb ? 32'hEDB88320 : 32'h0);
        end
        return r;
    endfunction

    task automatic build_frame(input int n, input int seed);
        logic [31:0] c;
        frm.delete();
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            frm.push_back(8'(i * 37 + seed));
            c = crc_update(c, frm[i]);
        end
        c = ~c;
        frm.push_back(c[7:0]);
        frm.push_back(c[15:8]);
        frm.push_back(c[23:16]);
        frm.push_back(c[31:24]);
    endtask

    task automatic expect_frame(input bit er, input bit fcs_ok);
        int total;
        int n_emit;
        bit good;
        exp_byte_t eb;
        exp_stat_t es;
        total = frm.size();
        if (total >= 5) begin
            n_emit = (total <= MAX_LEN) ? total - 4 : MAX_LEN - 4;
            for (int i = 0; i < n_emit; i++) begin
                eb.d   = frm[i];
                eb.sof = (i == 0);
                eb.eof = (total <= MAX_LEN) && (i == n_emit - 1);
                exp_data_q.push_back(eb);
            end
        end
        good = !er && total >= MIN_LEN && total <= MAX_LEN && (fcs_ok || !FCS_CHECKED);
        if (good) exp_good++;
        else      exp_bad++;
        es.good = good;
        es.len  = 11'((total >= 4) ? total - 4 : 0);
        es.gcnt = 16'(exp_good);
        es.bcnt = 16'(exp_bad);
        exp_stat_q.push_back(es);
    endtask

    task automatic drive(input logic [7:0] d, input logic dv, input logic er);
        @(negedge gmii_rx_clk);
        gmii_rxd   = d;
        gmii_rx_dv = dv;
        gmii_rx_er = er;
    endtask

    task automatic check_idle(input string tag);
        checks++;
        assert ({rx_valid, rx_sof, rx_eof, rx_stat_valid, rx_good, rx_frame_len, rx_data} === 24'd0)
        else begin
            errors++;
            $error("FAIL %s_outputs observed=%h expected=0", tag,
                   {rx_valid, rx_sof, rx_eof, rx_stat_valid, rx_good, rx_frame_len, rx_data});
        end
        checks++;
        assert ({good_cnt, bad_cnt} === 32'd0)
        else begin
            errors++;
            $error("FAIL %s_counters observed good=%0d bad=%0d expected 0/0", tag, good_cnt, bad_cnt);
        end
    endtask

    task automatic drive_frame(input int er_idx, input int abort_at, input int gap);
        for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0);
        drive(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < frm.size(); i++) begin
            drive(frm[i], 1'b1, i == er_idx);
            if (abort_at >= 0 && i == abort_at) begin
                reset = 1'b1;
                #1;
                check_idle("mid_reset");
            end
            if (abort_at >= 0 && i == abort_at + 1) reset = 1'b0;
        end
        for (int i = 0; i < gap; i++) drive(8'h00, 1'b0, 1'b0);
    endtask

    always @(posedge gmii_rx_clk) begin
        exp_byte_t eb;
        exp_stat_t es;
        #1;
        if (rx_valid === 1'b1) begin
            checks++;
            assert (exp_data_q.size() != 0)
            else begin
                errors++;
                $error("FAIL unexpected_byte observed=%h expected none", rx_data);
            end
            if (exp_data_q.size() != 0) begin
                eb = exp_data_q.pop_front();
                checks++;
                assert ({rx_data, rx_sof, rx_eof} === {eb.d, eb.sof, eb.eof})
                else begin
                    errors++;
                    $error("FAIL data observed=%h/sof%b/eof%b expected=%h/sof%b/eof%b",
                           rx_data, rx_sof, rx_eof, eb.d, eb.sof, eb.eof);
                end
            end
        end
        if (rx_stat_valid === 1'b1) begin
            checks++;
            assert (exp_stat_q.size() != 0)
            else begin
                errors++;
                $error("FAIL unexpected_status observed good=%b len=%0d", rx_good, rx_frame_len);
            end
            if (exp_stat_q.size() != 0) begin
                es = exp_stat_q.pop_front();
                checks++;
                assert ({rx_good, rx_frame_len, good_cnt, bad_cnt} === {es.good, es.len, es.gcnt, es.bcnt})
                else begin
                    errors++;
                    $error("FAIL status observed good=%b len=%0d gcnt=%0d bcnt=%0d expected good=%b len=%0d gcnt=%0d bcnt=%0d",
                           rx_good, rx_frame_len, good_cnt, bad_cnt, es.good, es.len, es.gcnt, es.bcnt);
                end
            end
        end
    end

    initial begin
        exp_byte_t eb;
        reset      = 1'b1;
        gmii_rxd   = 8'h00;
        gmii_rx_dv = 1'b0;
        gmii_rx_er = 1'b0;
        repeat (3) @(negedge gmii_rx_clk);
        check_idle("reset");
        reset = 1'b0;
        repeat (2) @(negedge gmii_rx_clk);

        // good 60-byte payload
        build_frame(60, 1);
        expect_frame(1'b0, 1'b1);
        drive_frame(-1, -1, 3);

        // one payload bit flipped
        build_frame(60, 1);
        frm[10] = frm[10] ^ 8'h04;
        expect_frame(1'b0, 1'b0);
        drive_frame(-1, -1, 3);

        // rx_er on payload byte 10
        build_frame(60, 2);
        expect_frame(1'b1, 1'b1);
        drive_frame(10, -1, 3);

        // runt: 3 bytes after SFD
        frm.delete();
        frm.push_back(8'hA1);
        frm.push_back(8'hB2);
        frm.push_back(8'hC3);
        expect_frame(1'b0, 1'b1);
        drive_frame(-1, -1, 3);

        // one byte under minimum
        build_frame(59, 3);
        expect_frame(1'b0, 1'b1);
        drive_frame(-1, -1, 3);

        // corrupt preamble and non-0x55 first byte: both dropped silently
        build_frame(20, 4);
        drive(8'h55, 1'b1, 1'b0);
        drive(8'h55, 1'b1, 1'b0);
        drive(8'h12, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) drive(8'h55, 1'b1, 1'b0);
        drive(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < frm.size(); i++) drive(frm[i], 1'b1, 1'b0);
        drive(8'h00, 1'b0, 1'b0);
        drive(8'hAA, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) drive(8'h55, 1'b1, 1'b0);
        drive(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < frm.size(); i++) drive(frm[i], 1'b1, 1'b0);
        repeat (3) drive(8'h00, 1'b0, 1'b0);

        // exactly maximum length
        build_frame(MAX_LEN - 4, 5);
        expect_frame(1'b0, 1'b1);
        drive_frame(-1, -1, 3);

        // oversize 1600-byte frame
        build_frame(1596, 6);
        expect_frame(1'b0, 1'b1);
        drive_frame(-1, -1, 3);

        // back-to-back with 1-cycle gaps
        build_frame(100, 7);
        expect_frame(1'b0, 1'b1);
        drive_frame(-1, -1, 1);
        build_frame(60, 8);
        expect_frame(1'b0, 1'b1);
        drive_frame(-1, -1, 1);

        // reset on payload byte 20: only bytes 0..14 made it out beforehand
        build_frame(60, 9);
        for (int i = 0; i < 15; i++) begin
            eb.d   = frm[i];
            eb.sof = (i == 0);
            eb.eof = 1'b0;
            exp_data_q.push_back(eb);
        end
        drive_frame(-1, 20, 1);
        exp_good = 0;
        exp_bad  = 0;

        build_frame(60, 10);
        expect_frame(1'b0, 1'b1);
        drive_frame(-1, -1, 3);

        for (int k = 0; k < 100 && (exp_data_q.size() != 0 || exp_stat_q.size() != 0); k++)
            @(negedge gmii_rx_clk);
        checks++;
        assert (exp_data_q.size() == 0 && exp_stat_q.size() == 0)
        else begin
            errors++;
            $error("FAIL drain observed pending bytes=%0d stats=%0d expected 0/0",
                   exp_data_q.size(), exp_stat_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gmii_rx_frame_parser.md
# gmii_rx_frame_parser

Receive-side framing stage fed directly by the RGMII-to-GMII bridge: consumes `gmii_rxd`/`gmii_rx_dv`/`gmii_rx_er` on `gmii_rx_clk`. It strips the preamble, SFD and FCS, checks the CRC-32, length and error flags, and delivers a byte stream with start/end markers and per-frame status to the MAC/UDP receive logic. It also keeps good and bad frame counters.

## Interface
Parameters:
- `MIN_FRAME_LEN`, 64: minimum legal length in bytes, DA through FCS inclusive.
- `MAX_FRAME_LEN`, 1518: maximum legal length in bytes, DA through FCS inclusive.

Ports (name, direction, width, meaning). One clock, `gmii_rx_clk`; reset `reset` is asynchronous, active-high.
- `gmii_rx_clk` in 1: 125 MHz receive clock.
- `reset` in 1: asynchronous, active-high.
- `gmii_rxd` in 8: GMII receive byte.
- `gmii_rx_dv` in 1: receive data valid.
- `gmii_rx_er` in 1: receive error.
- `rx_data` out 8: payload byte (DA onward, FCS excluded).
- `rx_valid` out 1: `rx_data` valid this cycle.
- `rx_sof` out 1: first payload byte; qualified by `rx_valid`.
- `rx_eof` out 1: last payload byte; qualified by `rx_valid`.
- `rx_stat_valid` out 1: one-cycle frame status pulse.
- `rx_good` out 1: frame OK; qualified by `rx_stat_valid`.
- `rx_frame_len` out 11: payload length excluding FCS; qualified by `rx_stat_valid`.
- `good_cnt` out 16: count of good frames; wraps.
- `bad_cnt` out 16: count of bad frames; wraps.

## Operation
- States: IDLE, PREAMBLE, DATA, DROP.
- IDLE: a frame starts only on a `gmii_rx_dv` rising edge, detected with registered `dv_d`. Reset value of `dv_d` is 1, so the tail of a frame interrupted by reset is ignored.
  - Rising edge with `rxd`=0x55 → PREAMBLE.
  - Rising edge with any other byte → DROP.
- PREAMBLE:
  - 0x55 → stay.
  - 0xD5 → DATA; clears CRC (to 0xFFFFFFFF), length counter, error flag and delay line.
  - Any other byte → DROP.
  - `dv`=0 → IDLE, no status.
- DATA:
  - Each `dv`=1 byte shifts into a 5-deep delay line, updates the CRC, and increments the 11-bit length counter (saturates at 2047).
  - Once the line holds 5 bytes, every push emits the oldest byte (`rx_valid`=1). The first emitted byte carries `rx_sof`.
  - `gmii_rx_er`=1 sets the sticky error flag.
  - When length exceeds `MAX_FRAME_LEN`, no further bytes are emitted; the frame is bad.
- End of frame: the first cycle with `dv`=0 in DATA → IDLE.
  - If the line holds 5 bytes and the frame is not oversize, emit the oldest byte with `rx_eof`=1. The remaining 4 bytes (FCS) are discarded.
  - In the same cycle: `rx_stat_valid`=1 and `rx_frame_len` = len−4, floored at 0.
  - `rx_good` = 1 only if all hold: error flag clear, `MIN_FRAME_LEN` ≤ len ≤ `MAX_FRAME_LEN`, and FCS OK.
  - The matching counter increments.
  - A runt of fewer than 5 bytes emits no data, only the status pulse with `rx_good`=0.
- DROP: wait for `dv`=0 → IDLE. No output, no counting.
- FCS check: reflected CRC-32 (poly 0xEDB88320), LSB-first, initial value 0xFFFFFFFF, run over DA through FCS. Pass if the final register equals 0xDEBB20E3.

## Timing
- Reset values: all outputs 0, both counters 0, state IDLE, `dv_d`=1.
- Latency: a payload byte sampled at edge N appears on `rx_data` after edge N+5. The last payload byte appears after the first `dv`=0 edge.
- `rx_eof` and `rx_stat_valid` coincide for normal frames.
- Back-to-back frames with a minimum 1-cycle `dv`=0 gap are fully supported. The gap cycle performs end-of-frame processing, and the next `dv` rising edge is accepted the following edge.
- No back-pressure: the consumer accepts one byte per cycle.
- Asynchronous reset mid-frame discards the frame: no `rx_eof`, no status pulse.

## Configuration
- Macro `GMII_RX_FCS_CHECK_EN` defined: the CRC datapath is built and FCS errors make `rx_good`=0.
- Macro undefined: no CRC logic, FCS is treated as OK. FCS bytes are still stripped and the length and error checks remain.

## Structure
- Package `gmii_rx_pkg`: state enum; constants PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, CRC_INIT=32'hFFFFFFFF, CRC_RESIDUE=32'hDEBB20E3.
- Sub-module `crc32_d8`: combinational one-byte reflected CRC-32 step (`crc_in`[31:0], `data`[7:0] → `crc_out`[31:0]). Instantiated only under `GMII_RX_FCS_CHECK_EN`.

## Test plan
- 7×0x55, 0xD5, then a 60-byte payload plus correct FCS → 60 bytes out; `rx_sof` on byte 0, `rx_eof` on byte 59; `rx_good`=1, `rx_frame_len`=60, `good_cnt`=1.
- Same frame with one payload bit flipped → identical data stream, `rx_good`=0, `bad_cnt`=1; with the macro undefined, `rx_good`=1.
- `gmii_rx_er` pulsed on payload byte 10 → `rx_good`=0.
- 3 bytes after SFD → no `rx_valid`; a single status pulse with `rx_good`=0 and `rx_frame_len`=0.
- 1600-byte frame → output stops after 1514 bytes with no `rx_eof`; status shows `rx_good`=0 and `rx_frame_len`=1596 (len saturates at 2047 only beyond that).
- Reset asserted on payload byte 20 while `dv` stays high → no further output or status. Next frame after a 1-cycle gap → parsed good.
